branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal direction predictor with direct-mapped BTB and one-stage push pipeline
module branch_predictor #(
    parameter int NR_BP_ENTRIES = 64,
    parameter int TAG_W         = 8,
    parameter int ID_W          = 6,
    parameter int BQID_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_pc,
    input  logic [ID_W-1:0]   req_id,
    input  logic [1:0]        req_kind,
    input  logic              flush,
    output logic              bq_push_valid,
    input  logic              bq_push_ready,
    output logic [64:0]       bq_push_bp,
    output logic [63:0]       bq_push_pc,
    output logic [ID_W-1:0]   bq_push_id,
    input  logic [BQID_W-1:0] bq_push_bqid,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [63:0]       pred_pcnext,
    output logic [BQID_W-1:0] pred_bqid,
    input  logic              upd_valid,
    input  logic [63:0]       upd_pc,
    input  logic [1:0]        upd_kind,
    input  logic              upd_taken,
    input  logic [63:0]       upd_target
);

    localparam int IDX_W  = $clog2(NR_BP_ENTRIES);
    localparam int TAG_LO = 2 + IDX_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NR_BP_ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_taken_q, s1_taken_d;
    logic [63:0]       s1_pcnext_q, s1_pcnext_d;
    logic [63:0]       s1_pc_q, s1_pc_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;

    // Tables have no reset; the INIT sweep is the only thing that clears them.
    logic [1:0]        ctr_q       [NR_BP_ENTRIES];
    logic              btb_valid_q [NR_BP_ENTRIES];
    logic [TAG_W-1:0]  btb_tag_q   [NR_BP_ENTRIES];
    logic [63:0]       btb_tgt_q   [NR_BP_ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit, lk_jump, lk_taken, lk_use_tgt;
    logic [63:0]       lk_pcnext;

    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_cond, upd_en;
    logic              push_fire, accept;
    logic              unused_upd_pc;

    assign lk_idx  = req_pc[IDX_W+1:2];
    assign lk_tag  = req_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[TAG_LO+TAG_W-1:TAG_LO];
    assign unused_upd_pc = ^{upd_pc[63:TAG_LO+TAG_W], upd_pc[1:0]};

    // Reserved kind 2'b11 decodes as a conditional branch.
    assign lk_jump  = (req_kind == 2'b01) || (req_kind == 2'b10);
    assign upd_cond = !((upd_kind == 2'b01) || (upd_kind == 2'b10));
    assign upd_en   = upd_valid && (state_q == ST_RUN);

    always_comb begin
        lk_hit     = 1'b0;
        lk_taken   = 1'b0;
        lk_use_tgt = 1'b0;
        lk_pcnext  = req_pc + 64'd4;
        lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        lk_taken   = lk_jump || (ctr_q[lk_idx][1] && lk_hit);
        lk_use_tgt = lk_hit && (lk_jump || ctr_q[lk_idx][1]);
        if (lk_use_tgt) begin
            lk_pcnext = btb_tgt_q[lk_idx];
        end
    end

    assign bq_push_valid = s1_valid_q && !flush;
    assign push_fire     = bq_push_valid && bq_push_ready;
    assign req_ready     = (state_q == ST_RUN) && (!s1_valid_q || push_fire);
    assign accept        = req_valid && req_ready;

    assign bq_push_bp  = {s1_taken_q, s1_pcnext_q};
    assign bq_push_pc  = s1_pc_q;
    assign bq_push_id  = s1_id_q;
    assign pred_valid  = push_fire;
    assign pred_taken  = s1_taken_q;
    assign pred_pcnext = s1_pcnext_q;
    assign pred_bqid   = push_fire ? bq_push_bqid : '0;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        s1_valid_d  = s1_valid_q;
        s1_taken_d  = s1_taken_q;
        s1_pcnext_d = s1_pcnext_q;
        s1_pc_d     = s1_pc_q;
        s1_id_d     = s1_id_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IDX_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
        // A flush also discards a request accepted in the same cycle.
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d  = 1'b1;
            s1_taken_d  = lk_taken;
            s1_pcnext_d = lk_pcnext;
            s1_pc_d     = req_pc;
            s1_id_d     = req_id;
        end else if (push_fire) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_idx_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_taken_q  <= 1'b0;
            s1_pcnext_q <= '0;
            s1_pc_q     <= '0;
            s1_id_q     <= '0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            s1_valid_q  <= s1_valid_d;
            s1_taken_q  <= s1_taken_d;
            s1_pcnext_q <= s1_pcnext_d;
            s1_pc_q     <= s1_pc_d;
            s1_id_q     <= s1_id_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            ctr_q[init_idx_q]       <= 2'b01;
            btb_valid_q[init_idx_q] <= 1'b0;
        end else if (upd_en) begin
            if (upd_cond) begin
                if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
                end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
                end
            end
            if (upd_taken) begin
                btb_valid_q[upd_idx] <= 1'b1;
                btb_tag_q[upd_idx]   <= upd_tag;
                btb_tgt_q[upd_idx]   <= upd_target;
            end
        end
    end

endmodule
